// File: rtl/stream_arb2_pkg.sv
// Shared types and source encodings for the two-input stream arbiter.
package stream_arb2_pkg;

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} lock_state_t;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way grant: packet lock forcing first, then the single valid
// source, otherwise the round-robin priority pointer.
module rr_grant2
    import stream_arb2_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic prio,
    input  logic force_a,
    input  logic force_b,
    output logic sel
);

    always_comb begin
        sel = prio;
        if (force_a) begin
            sel = SRC_A;
        end else if (force_b) begin
            sel = SRC_B;
        end else if (a_valid && !b_valid) begin
            sel = SRC_A;
        end else if (b_valid && !a_valid) begin
            sel = SRC_B;
        end
    end

endmodule

// File: rtl/stream_arb2.sv
// Two-input round-robin stream arbiter with a registered output stage.
// Optional packet lock is enabled by defining STREAM_ARB2_LOCK_EN.
module stream_arb2
    import stream_arb2_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic             sel,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_last,
    output logic             o_src,
    input  logic             o_ready
);

    logic prio;
    logic space;
    logic in_xfer;
    logic src_last;
    logic prio_upd;
    logic force_a;
    logic force_b;

    rr_grant2 u_grant (
        .a_valid (a_valid),
        .b_valid (b_valid),
        .prio    (prio),
        .force_a (force_a),
        .force_b (force_b),
        .sel     (sel)
    );

    // rst_n gates the readies so nothing upstream sees a handshake during reset
    assign space   = !o_valid || o_ready;
    assign a_ready = rst_n && space && (sel == SRC_A);
    assign b_ready = rst_n && space && (sel == SRC_B);
    assign in_xfer = (a_ready && a_valid) || (b_ready && b_valid);

`ifdef STREAM_ARB2_LOCK_EN
    lock_state_t lock_state;

    assign force_a  = (lock_state == LOCK_A);
    assign force_b  = (lock_state == LOCK_B);
    assign src_last = (sel == SRC_A) ? a_last : b_last;
    assign prio_upd = in_xfer && src_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= IDLE;
        end else if (in_xfer) begin
            if (src_last) begin
                lock_state <= IDLE;
            end else begin
                lock_state <= (sel == SRC_A) ? LOCK_A : LOCK_B;
            end
        end
    end
`else
    logic unused_last;

    assign force_a     = 1'b0;
    assign force_b     = 1'b0;
    assign src_last    = 1'b0;
    assign prio_upd    = in_xfer;
    assign unused_last = a_last ^ b_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_src   <= SRC_B;
            prio    <= SRC_A;
        end else begin
            if (in_xfer) begin
                o_valid <= 1'b1;
                o_data  <= (sel == SRC_A) ? a_data : b_data;
                o_last  <= src_last;
                o_src   <= sel;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
            if (prio_upd) begin
                prio <= !sel;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2: directed vector table, hand-written
// reset/lock sequences and a randomized run against a behavioural model.
module tb_stream_arb2;

`ifdef STREAM_ARB2_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_data = '0, b_data = '0, o_data;
    logic        a_valid = 1'b0, a_last = 1'b0, a_ready;
    logic        b_valid = 1'b0, b_last = 1'b0, b_ready;
    logic        sel, o_valid, o_last, o_src;
    logic        o_ready = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    stream_arb2 #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .sel(sel), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
        .o_src(o_src), .o_ready(o_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        av, bv, ordy;
        logic [31:0] ad, bd;
        logic        e_sel, e_ar, e_br, e_ov, e_src;
        logic [31:0] e_od;
    } vec_t;

    vec_t vecs[13];

    // behavioural model state (random phase)
    logic        m_valid, m_last, m_src, m_prio;
    logic [31:0] m_data;
    int          m_lock; // 0 none, 1 locked to A, 2 locked to B

    initial begin
        logic [31:0] exp_d[4];
        logic        exp_s[4];
        logic        exp_l[4];
        int          a_idx;
        logic        acc;

        // {av,bv,ordy, ad, bd, sel,ar,br, ov,src, od}
        vecs[0]  = '{1,1,1, 32'hA1, 32'hB1, 1,1,0, 1,1, 32'hA1};
        vecs[1]  = '{1,1,1, 32'hA1, 32'hB1, 0,0,1, 1,0, 32'hB1};
        vecs[2]  = '{1,1,1, 32'hA1, 32'hB1, 1,1,0, 1,1, 32'hA1};
        vecs[3]  = '{1,1,1, 32'hA1, 32'hB1, 0,0,1, 1,0, 32'hB1};
        vecs[4]  = '{0,1,1, 32'h0,  32'h1,  0,0,1, 1,0, 32'h1};
        vecs[5]  = '{0,1,1, 32'h0,  32'h2,  0,0,1, 1,0, 32'h2};
        vecs[6]  = '{0,1,1, 32'h0,  32'h3,  0,0,1, 1,0, 32'h3};
        vecs[7]  = '{1,0,1, 32'h55, 32'h0,  1,1,0, 1,1, 32'h55};
        vecs[8]  = '{1,1,0, 32'h66, 32'h77, 0,0,0, 1,1, 32'h55};
        vecs[9]  = '{1,1,0, 32'h66, 32'h77, 0,0,0, 1,1, 32'h55};
        vecs[10] = '{1,1,1, 32'h66, 32'h77, 0,0,1, 1,0, 32'h77};
        vecs[11] = '{0,0,1, 32'h0,  32'h0,  1,1,0, 0,0, 32'h77};
        vecs[12] = '{0,0,0, 32'h0,  32'h0,  1,1,0, 0,0, 32'h77};

        // reset values while rst_n is low, o_ready high
        o_ready = 1'b1;
        #2;
        check("rst_o_valid", 32'(o_valid), 32'h0);
        check("rst_o_data", o_data, 32'h0);
        check("rst_o_src", 32'(o_src), 32'h0);
        check("rst_o_last", 32'(o_last), 32'h0);
        check("rst_a_ready", 32'(a_ready), 32'h0);
        check("rst_b_ready", 32'(b_ready), 32'h0);
        do_reset();

        a_last = 1'b1; b_last = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a_valid = vecs[i].av; b_valid = vecs[i].bv; o_ready = vecs[i].ordy;
            a_data = vecs[i].ad;  b_data = vecs[i].bd;
            #1;
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].e_sel));
            check($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].e_ar));
            check($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].e_br));
            @(posedge clk); #1;
            check($sformatf("vec%0d_o_valid", i), 32'(o_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_o_src", i), 32'(o_src), 32'(vecs[i].e_src));
            check($sformatf("vec%0d_o_data", i), o_data, vecs[i].e_od);
        end

        // reset mid-stream with a held word
        @(negedge clk);
        a_valid = 1'b1; a_data = 32'hDEAD_BEEF; b_valid = 1'b0; o_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; o_ready = 1'b0;
        check("mid_loaded", o_data, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0; o_ready = 1'b1;
        #1;
        check("mid_rst_o_valid", 32'(o_valid), 32'h0);
        check("mid_rst_o_data", o_data, 32'h0);
        check("mid_rst_a_ready", 32'(a_ready), 32'h0);
        check("mid_rst_b_ready", 32'(b_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 32'hA2; b_data = 32'hB2;
        #1;
        check("post_rst_sel", 32'(sel), 32'h1);
        @(posedge clk); #1;
        check("post_rst_o_data", o_data, 32'hA2);

        // 3-word A packet against continuously valid B
        do_reset();
        if (LOCK_ON) begin
            exp_s = '{1, 1, 1, 0}; exp_l = '{0, 0, 1, 1};
            exp_d = '{32'h1, 32'h2, 32'h3, 32'hB3};
        end else begin
            exp_s = '{1, 0, 1, 0}; exp_l = '{0, 0, 0, 0};
            exp_d = '{32'h1, 32'hB1, 32'h2, 32'hB3};
        end
        a_idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_valid = (a_idx < 3); a_data = 32'(a_idx + 1); a_last = (a_idx == 2);
            b_valid = 1'b1; b_data = 32'hB0 + 32'(c); b_last = 1'b1; o_ready = 1'b1;
            #1;
            acc = a_valid && a_ready;
            @(posedge clk); #1;
            if (acc) a_idx++;
            check($sformatf("pkt%0d_o_src", c), 32'(o_src), 32'(exp_s[c]));
            check($sformatf("pkt%0d_o_last", c), 32'(o_last), 32'(exp_l[c]));
            check($sformatf("pkt%0d_o_data", c), o_data, exp_d[c]);
        end

        // randomized run against the behavioural model
        do_reset();
        m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_src = 1'b0; m_prio = 1'b1; m_lock = 0;
        for (int n = 0; n < 400; n++) begin
            logic g, stall, take, slast;
            @(negedge clk);
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_data = $urandom; b_data = $urandom;
            a_last = ($urandom_range(0, 2) == 0);
            b_last = ($urandom_range(0, 2) == 0);
            o_ready = ($urandom_range(0, 9) < 7);
            #1;
            stall = m_valid && !o_ready;
            if (m_lock == 1) g = 1'b1;
            else if (m_lock == 2) g = 1'b0;
            else if (a_valid != b_valid) g = a_valid;
            else g = m_prio;
            check("rnd_sel", 32'(sel), 32'(g));
            check("rnd_a_ready", 32'(a_ready), 32'(!stall && g));
            check("rnd_b_ready", 32'(b_ready), 32'(!stall && !g));
            take  = !stall && (g ? a_valid : b_valid);
            slast = g ? a_last : b_last;
            if (take) begin
                m_valid = 1'b1;
                m_data  = g ? a_data : b_data;
                m_last  = LOCK_ON && slast;
                m_src   = g;
                if (!LOCK_ON || slast) m_prio = !g;
                if (LOCK_ON) m_lock = slast ? 0 : (g ? 1 : 2);
            end else if (m_valid && o_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("rnd_o_valid", 32'(o_valid), 32'(m_valid));
            check("rnd_o_data", o_data, m_data);
            check("rnd_o_last", 32'(o_last), 32'(m_last));
            check("rnd_o_src", 32'(o_src), 32'(m_src));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_arb2.md
# stream_arb2

Two-input round-robin stream arbiter with a registered output stage. It sits directly upstream of the 2:1 data multiplexer stage. It accepts two valid/ready word streams, A and B. It drives the multiplexer select and forwards the granted word to a single registered output stream. The select polarity is fixed: `sel=1` picks A and `sel=0` picks B.

## Interface
- `WIDTH`, default 32: data word width in bits, ≥1.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `a_data`  in  WIDTH  stream A word.
- `a_valid`  in  1  stream A word present.
- `a_last`  in  1  stream A end-of-packet; used only when `STREAM_ARB2_LOCK_EN` is defined.
- `a_ready`  out  1  stream A word accepted this cycle when high with `a_valid`.
- `b_data`, `b_valid`, `b_last`, `b_ready`: same as the A ports, for stream B.
- `sel`  out  1  multiplexer select for the current grant; 1 = A, 0 = B.
- `o_data`  out  WIDTH  registered output word.
- `o_valid`  out  1  registered output word valid.
- `o_last`  out  1  registered copy of the granted source's last flag.
- `o_src`  out  1  source of the word in the output register; 1 = A, 0 = B.
- `o_ready`  in  1  downstream accepts the output word.

## Operation
- **Transfer rule.** A transfer on any port occurs when valid and ready are both high at a rising edge.
- **Space signal.** `space = !o_valid || o_ready`; the output register can take a word this cycle.
- **Grant, only A valid.** Grant goes to A.
- **Grant, only B valid.** Grant goes to B.
- **Grant, both valid.** Grant goes to the source indicated by priority pointer `prio` (1 = A).
- **Grant, neither valid.** Grant goes to `prio`.
- **Select.** `sel` = grant.
- **Readies.**
  - `a_ready = space && sel`.
  - `b_ready = space && !sel`.
  - At most one ready is high per cycle.
  - Readies depend combinationally on `o_ready`, `a_valid` and `b_valid`; they do not depend on data.
- **On an input transfer:**
  - `o_data` takes the granted source's data.
  - `o_last` takes the granted source's last flag; it is forced to 0 when `a_valid`/`b_valid` data is not packetised, i.e. when lock is disabled.
  - `o_src` takes `sel`.
  - `o_valid` is set to 1.
  - `prio` is set to `!sel`: the other source has priority next time.
- **Output drain only.** If the output transfers and no input transfers that cycle, `o_valid` goes to 0; `o_data`, `o_last` and `o_src` hold.
- **Simultaneous drain and fill.** The new word replaces the drained one. `o_valid` stays 1, giving full throughput of one word per cycle.
- **Stall.** While `o_valid && !o_ready`, all output registers hold and both readies are 0.
- **Fairness.** With both sources continuously valid and `o_ready=1`, grants alternate A, B, A, B, starting from `prio`.

## Timing
- Latency is one cycle: a word accepted at edge N is presented on `o_data` with `o_valid=1` after edge N.
- **Reset values** (asynchronous, immediate on `rst_n` low):
  - `o_valid=0`, `o_data=0`, `o_last=0`, `o_src=0`.
  - `prio=1` (A first).
  - Lock state IDLE.
- While `rst_n` is low, `a_ready=0` and `b_ready=0` regardless of `o_ready`.
- **Reset mid-operation.** Any held output word and lock are discarded. No transfer occurs on the edge at which reset is released.
- Deassertion of `rst_n` is synchronous to `clk` at system level; the block does not resynchronise it.

## Configuration
- Macro: `STREAM_ARB2_LOCK_EN`.
- **Defined: packet lock.** Three-state FSM.
  - IDLE: grant follows the round-robin rule above.
  - IDLE to LOCK_A: on an A transfer with `a_last=0`.
  - IDLE to LOCK_B: on a B transfer with `b_last=0`.
  - LOCK_A: `sel` is forced to 1 regardless of `b_valid`.
  - LOCK_A to IDLE: on an A transfer with `a_last=1`.
  - LOCK_B: mirror image of LOCK_A.
  - IDLE with a `last=1` transfer stays in IDLE (single-word packet).
  - `prio` updates only on transfers with `last=1`.
  - `o_last` carries the source's last flag.
- **Undefined.**
  - No FSM.
  - `a_last` and `b_last` are ignored.
  - `o_last` is constant 0.
  - `prio` updates on every transfer.

## Structure
- Package `stream_arb2_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} lock_state_t`.
  - Source constants `SRC_A=1'b1` and `SRC_B=1'b0`.
- Sub-module `rr_grant2` holds the pure combinational grant logic.
  - Inputs: `a_valid`, `b_valid`, `prio`, force-A, force-B.
  - Output: `sel`.
  - The top level holds `prio`, the FSM and the output register.

## Test plan
- **Reset.** Assert `rst_n=0` mid-stream with `o_valid=1`, `o_data=32'hDEAD_BEEF` -> immediately `o_valid=0`, `o_data=0`, readies 0. After release, the first grant with both valid goes to A.
- **Alternation.** Both valid, `a_data=32'h0000_00A1`, `b_data=32'h0000_00B1`, `o_ready=1` for 4 cycles -> output sequence A1, B1, A1, B1. `o_src` = 1, 0, 1, 0. One word per cycle.
- **Single source.** Only B valid for 3 cycles, values 1, 2, 3 -> `sel=0`, `o_data` = 1, 2, 3 on consecutive cycles. `a_ready` stays 0.
- **Backpressure.** `o_ready=0` while `o_valid=1` with `o_data=32'h55` -> `o_data` holds 32'h55 and both readies are 0. Raising `o_ready` drains the word and accepts the next word in the same cycle.
- **Lock (macro defined).** A sends a 3-word packet (last on word 3) while B is continuously valid -> three A words are output contiguously with `o_last`=0, 0, 1. B is granted on the following cycle.
- **Lock off (macro undefined).** Same stimulus -> words interleave A, B, A, B and `o_last` stays 0.
